// File: rtl/stash_op1_out.sv
// Egress half of the op1 stash path: drains the op1 packet FIFO onto an AXI4-Stream master,
// patching the IPv4 checksum, swapping UDP ports and zeroing the UDP checksum on IPv4/UDP packets.
module stash_op1_out #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                axis_aclk,
  input  logic                                axis_reset,
  input  logic                                i_pkt_fifo_empty,
  output logic                                o_pkt_fifo_rd_en,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      i_tdata_fifo,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     i_tuser_fifo,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    i_tkeep_fifo,
  input  logic                                i_tlast_fifo,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [31:0]                         o_pkt_cnt,
  output logic [31:0]                         o_mod_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT1 = 3'd1;
  localparam logic [2:0] S_SEND0 = 3'd2;
  localparam logic [2:0] S_SEND1 = 3'd3;
  localparam logic [2:0] S_BODY  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] b0_data_q, b0_data_d;
  logic [UW-1:0] b0_user_q, b0_user_d;
  logic [KW-1:0] b0_keep_q, b0_keep_d;
  logic          b0_last_q, b0_last_d;
  logic [DW-1:0] b1_data_q, b1_data_d;
  logic [UW-1:0] b1_user_q, b1_user_d;
  logic [KW-1:0] b1_keep_q, b1_keep_d;
  logic          b1_last_q, b1_last_d;
  logic          qual_q, qual_d;
  logic [19:0]   psum_q, psum_d;
  logic [15:0]   csum_q, csum_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;
  logic [31:0]   mod_cnt_q, mod_cnt_d;
  logic          rd;

  // Header words 7..15 of beat0, skipping word 12 (the stale checksum field itself).
  function automatic logic [19:0] sum_beat0(input logic [DW-1:0] d);
    logic [19:0] s;
    s = '0;
    for (int i = 7; i < 16; i++) begin
      if (i != 12) s = s + {4'b0, d[16*i +: 16]};
    end
    return s;
  endfunction

  function automatic logic [15:0] fold_csum(input logic [19:0] s);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, s[15:0]} + {13'b0, s[19:16]};
    s2 = {1'b0, s1[15:0]} + {16'b0, s1[16]};
    return ~s2[15:0];
  endfunction

  function automatic logic is_ipv4_udp(input logic [DW-1:0] d);
    return (d[111:96] == 16'h0008) && (d[115:112] == 4'h5) && (d[191:184] == 8'h11);
  endfunction

  always_comb begin
    state_d   = state_q;
    b0_data_d = b0_data_q;
    b0_user_d = b0_user_q;
    b0_keep_d = b0_keep_q;
    b0_last_d = b0_last_q;
    b1_data_d = b1_data_q;
    b1_user_d = b1_user_q;
    b1_keep_d = b1_keep_q;
    b1_last_d = b1_last_q;
    qual_d    = qual_q;
    psum_d    = psum_q;
    csum_d    = csum_q;
    pkt_cnt_d = pkt_cnt_q;
    mod_cnt_d = mod_cnt_q;
    rd            = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;

    case (state_q)
      S_IDLE: begin
        rd = !i_pkt_fifo_empty;
        if (rd) begin
          b0_data_d = i_tdata_fifo;
          b0_user_d = i_tuser_fifo;
          b0_keep_d = i_tkeep_fifo;
          b0_last_d = i_tlast_fifo;
          // A single-beat packet has no beat1 to finish the sum, so it leaves unmodified.
          qual_d    = is_ipv4_udp(i_tdata_fifo) && !i_tlast_fifo;
          psum_d    = sum_beat0(i_tdata_fifo);
          state_d   = i_tlast_fifo ? S_SEND0 : S_WAIT1;
        end
      end
      S_WAIT1: begin
        rd = !i_pkt_fifo_empty;
        if (rd) begin
          b1_data_d = i_tdata_fifo;
          b1_user_d = i_tuser_fifo;
          b1_keep_d = i_tkeep_fifo;
          b1_last_d = i_tlast_fifo;
          csum_d    = fold_csum(psum_q + {4'b0, i_tdata_fifo[15:0]});
          state_d   = S_SEND0;
        end
      end
      S_SEND0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = b0_data_q;
        if (qual_q) m_axis_tdata[207:192] = csum_q;
        m_axis_tkeep  = b0_keep_q;
        m_axis_tuser  = b0_user_q;
        m_axis_tlast  = b0_last_q;
        if (m_axis_tready) begin
          if (b0_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_SEND1;
          end
        end
      end
      S_SEND1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = b1_data_q;
        if (qual_q) begin
          m_axis_tdata[31:16] = b1_data_q[47:32];
          m_axis_tdata[47:32] = b1_data_q[31:16];
          m_axis_tdata[79:64] = 16'h0000;
        end
        m_axis_tkeep  = b1_keep_q;
        m_axis_tuser  = b1_user_q;
        m_axis_tlast  = b1_last_q;
        if (m_axis_tready) begin
          if (qual_q) mod_cnt_d = mod_cnt_q + 32'd1;
          if (b1_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_BODY;
          end
        end
      end
      S_BODY: begin
        m_axis_tvalid = !i_pkt_fifo_empty;
        m_axis_tdata  = i_tdata_fifo;
        m_axis_tkeep  = i_tkeep_fifo;
        m_axis_tuser  = i_tuser_fifo;
        m_axis_tlast  = i_tlast_fifo;
        rd = m_axis_tvalid && m_axis_tready;
        if (rd && i_tlast_fifo) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Never pop while reset is held; the FIFO owner is flushing it.
  assign o_pkt_fifo_rd_en = rd && !axis_reset;
  assign o_pkt_cnt        = pkt_cnt_q;
  assign o_mod_cnt        = mod_cnt_q;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q   <= S_IDLE;
      b0_data_q <= '0;
      b0_user_q <= '0;
      b0_keep_q <= '0;
      b0_last_q <= 1'b0;
      b1_data_q <= '0;
      b1_user_q <= '0;
      b1_keep_q <= '0;
      b1_last_q <= 1'b0;
      qual_q    <= 1'b0;
      psum_q    <= '0;
      csum_q    <= '0;
      pkt_cnt_q <= '0;
      mod_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      b0_data_q <= b0_data_d;
      b0_user_q <= b0_user_d;
      b0_keep_q <= b0_keep_d;
      b0_last_q <= b0_last_d;
      b1_data_q <= b1_data_d;
      b1_user_q <= b1_user_d;
      b1_keep_q <= b1_keep_d;
      b1_last_q <= b1_last_d;
      qual_q    <= qual_d;
      psum_q    <= psum_d;
      csum_q    <= csum_d;
      pkt_cnt_q <= pkt_cnt_d;
      mod_cnt_q <= mod_cnt_d;
    end
  end

endmodule

// File: tb/tb_stash_op1_out.sv
// Directed bench for stash_op1_out: a small FIFO model feeds hand-built packets and each
// scenario task compares captured output beats against hand-computed expectations.
module tb_stash_op1_out;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic          rd_en;
  logic [DW-1:0] fdata;
  logic [UW-1:0] fuser;
  logic [KW-1:0] fkeep;
  logic          flast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [31:0]   pkt_cnt;
  logic [31:0]   mod_cnt;

  always #5 clk = ~clk;

  stash_op1_out #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .i_pkt_fifo_empty(empty), .o_pkt_fifo_rd_en(rd_en),
    .i_tdata_fifo(fdata), .i_tuser_fifo(fuser), .i_tkeep_fifo(fkeep), .i_tlast_fifo(flast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .o_pkt_cnt(pkt_cnt), .o_mod_cnt(mod_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] in_data [32];
  logic [UW-1:0] in_user [32];
  logic [KW-1:0] in_keep [32];
  logic          in_last [32];
  int            gap     [32];
  int            n_in;

  logic [DW-1:0] out_data [32];
  logic [UW-1:0] out_user [32];
  logic [KW-1:0] out_keep [32];
  logic          out_last [32];
  int            n_out, pops, stab_viol, bubble_viol;

  logic [DW-1:0] exp_data [32];

  // Header words sum to 0x19446; with dst-IP tail 0xB9D1 the folded checksum is 0xB1E6.
  function automatic logic [DW-1:0] mk_beat0(input logic [7:0] proto);
    logic [DW-1:0] d;
    d = '0;
    d[95:0]    = 96'h665544332211_BBAA99887766;
    d[111:96]  = 16'h0008;
    d[127:112] = 16'h0045;
    d[143:128] = 16'h3000;
    d[159:144] = 16'h0000;
    d[175:160] = 16'h0040;
    d[191:176] = {proto, 8'h40};
    d[207:192] = 16'hFFFF;
    d[223:208] = 16'hA8C0;
    d[239:224] = 16'h0101;
    d[255:240] = 16'hA8C0;
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_beat1();
    return {{11{16'h5A5A}}, 16'hABCD, 16'h5678, 16'hb822, 16'h1234, 16'hB9D1};
  endfunction

  task automatic clear_pkt();
    n_in = 0;
    for (int i = 0; i < 32; i++) gap[i] = 0;
  endtask

  task automatic add_beat(input logic [DW-1:0] d, input logic l);
    in_data[n_in] = d;
    in_user[n_in] = {96'h0, 32'hC0DE0000 + 32'(n_in)};
    in_keep[n_in] = l ? 32'h0000FFFF : 32'hFFFFFFFF;
    in_last[n_in] = l;
    exp_data[n_in] = d;
    n_in++;
  endtask

  task automatic add_udp_patches(input int base);
    exp_data[base][207:192]   = 16'hB1E6;
    exp_data[base+1][31:16]   = 16'hb822;
    exp_data[base+1][47:32]   = 16'h1234;
    exp_data[base+1][79:64]   = 16'h0000;
  endtask

  task automatic run_pkt(input bit rand_ready, input int stop_out, input int max_cyc);
    int ptr;
    logic prev_hold;
    logic [DW-1:0] h_data;
    logic [KW-1:0] h_keep;
    logic [UW-1:0] h_user;
    logic h_last;
    ptr = 0; n_out = 0; pops = 0; stab_viol = 0; bubble_viol = 0; prev_hold = 1'b0;
    h_data = '0; h_keep = '0; h_user = '0; h_last = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (ptr < n_in && gap[ptr] > 0) begin
        empty = 1'b1;
        gap[ptr] = gap[ptr] - 1;
      end else if (ptr < n_in) begin
        empty = 1'b0;
      end else begin
        empty = 1'b1;
      end
      if (empty) begin
        fdata = {8{32'hDEADBEEF}}; fuser = '1; fkeep = '1; flast = 1'b1;
      end else begin
        fdata = in_data[ptr]; fuser = in_user[ptr]; fkeep = in_keep[ptr]; flast = in_last[ptr];
      end
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_hold && (m_tvalid !== 1'b1 || m_tdata !== h_data || m_tkeep !== h_keep ||
                        m_tuser !== h_user || m_tlast !== h_last)) stab_viol++;
      prev_hold = (m_tvalid === 1'b1) && !m_tready;
      h_data = m_tdata; h_keep = m_tkeep; h_user = m_tuser; h_last = m_tlast;
      if (empty && ptr < n_in && n_out >= 2 && m_tvalid === 1'b1) bubble_viol++;
      if (rd_en === 1'b1 && empty) bubble_viol++;
      if (m_tvalid === 1'b1 && m_tready && n_out < 32) begin
        out_data[n_out] = m_tdata; out_user[n_out] = m_tuser;
        out_keep[n_out] = m_tkeep; out_last[n_out] = m_tlast;
        n_out++;
      end
      if (rd_en === 1'b1 && !empty) begin
        ptr++;
        pops++;
      end
      if (n_out >= stop_out) break;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      empty = 1'b1; m_tready = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; empty = 1'b1; m_tready = 1'b0;
    fdata = '0; fuser = '0; fkeep = '0; flast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got tvalid=%b tlast=%b rd_en=%b, want 0 0 0", m_tvalid, m_tlast, rd_en);
    end
    n_checks++;
    if (m_tdata !== '0 || m_tkeep !== '0 || m_tuser !== '0) begin
      n_fail++; $display("FAIL reset_data: got tdata=%h, want 0", m_tdata);
    end
    n_checks++;
    if (pkt_cnt !== 32'd0 || mod_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got pkt=%0d mod=%0d, want 0 0", pkt_cnt, mod_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_udp();
    logic [31:0] p0, m0;
    p0 = pkt_cnt; m0 = mod_cnt;
    clear_pkt();
    add_beat(mk_beat0(8'h11), 1'b0);
    add_beat(mk_beat1(), 1'b0);
    add_beat({8{32'h0BADF00D}}, 1'b1);
    add_udp_patches(0);
    run_pkt(1'b0, 3, 100);
    idle(2);
    n_checks++;
    if (n_out !== 3) begin n_fail++; $display("FAIL udp_nbeats: got %0d, want 3", n_out); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_data[i] !== exp_data[i] || out_keep[i] !== in_keep[i] ||
          out_user[i] !== in_user[i] || out_last[i] !== in_last[i]) begin
        n_fail++; $display("FAIL udp_beat%0d: got %h, want %h", i, out_data[i], exp_data[i]);
      end
    end
    n_checks++;
    if (out_data[0][207:192] !== 16'hB1E6) begin
      n_fail++; $display("FAIL udp_ipcsum: got %h, want b1e6", out_data[0][207:192]);
    end
    n_checks++;
    if (pkt_cnt - p0 !== 32'd1 || mod_cnt - m0 !== 32'd1) begin
      n_fail++; $display("FAIL udp_cnt: got pkt+%0d mod+%0d, want +1 +1", pkt_cnt - p0, mod_cnt - m0);
    end
  endtask

  task automatic test_non_udp();
    logic [31:0] p0, m0;
    p0 = pkt_cnt; m0 = mod_cnt;
    clear_pkt();
    add_beat(mk_beat0(8'h06), 1'b0);
    add_beat(mk_beat1(), 1'b1);
    run_pkt(1'b0, 2, 100);
    idle(2);
    n_checks++;
    if (n_out !== 2) begin n_fail++; $display("FAIL tcp_nbeats: got %0d, want 2", n_out); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_data[i] !== in_data[i] || out_last[i] !== in_last[i] || out_keep[i] !== in_keep[i]) begin
        n_fail++; $display("FAIL tcp_beat%0d: got %h, want %h", i, out_data[i], in_data[i]);
      end
    end
    n_checks++;
    if (pkt_cnt - p0 !== 32'd1 || mod_cnt - m0 !== 32'd0) begin
      n_fail++; $display("FAIL tcp_cnt: got pkt+%0d mod+%0d, want +1 +0", pkt_cnt - p0, mod_cnt - m0);
    end
  endtask

  task automatic test_single_beat();
    logic [31:0] p0, m0;
    p0 = pkt_cnt; m0 = mod_cnt;
    clear_pkt();
    add_beat(mk_beat0(8'h11), 1'b1);
    run_pkt(1'b0, 1, 100);
    idle(2);
    n_checks++;
    if (n_out !== 1 || out_data[0] !== in_data[0] || out_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_beat: got n=%0d last=%b data=%h, want 1 1 %h", n_out, out_last[0], out_data[0], in_data[0]);
    end
    n_checks++;
    if (dut.state_q !== 3'd0) begin
      n_fail++; $display("FAIL single_idle: got state %0d, want 0", dut.state_q);
    end
    n_checks++;
    if (pkt_cnt - p0 !== 32'd1 || mod_cnt - m0 !== 32'd0) begin
      n_fail++; $display("FAIL single_cnt: got pkt+%0d mod+%0d, want +1 +0", pkt_cnt - p0, mod_cnt - m0);
    end
  endtask

  task automatic test_random_ready();
    logic [31:0] m0;
    m0 = mod_cnt;
    clear_pkt();
    add_beat(mk_beat0(8'h11), 1'b0);
    add_beat(mk_beat1(), 1'b0);
    for (int i = 2; i < 10; i++) add_beat({8{32'h01010101 * 32'(i)}}, i == 9);
    add_udp_patches(0);
    run_pkt(1'b1, 10, 400);
    idle(2);
    n_checks++;
    if (n_out !== 10 || pops !== 10) begin
      n_fail++; $display("FAIL rand_count: got beats=%0d pops=%0d, want 10 10", n_out, pops);
    end
    n_checks++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL rand_stable: got %0d violations, want 0", stab_viol); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== in_last[i] || out_user[i] !== in_user[i]) begin
        n_fail++; $display("FAIL rand_beat%0d: got %h, want %h", i, out_data[i], exp_data[i]);
      end
    end
    n_checks++;
    if (mod_cnt - m0 !== 32'd1) begin n_fail++; $display("FAIL rand_mod: got +%0d, want +1", mod_cnt - m0); end
  endtask

  task automatic test_fifo_gaps();
    clear_pkt();
    add_beat(mk_beat0(8'h11), 1'b0);
    add_beat(mk_beat1(), 1'b0);
    add_beat({8{32'h11112222}}, 1'b0);
    add_beat({8{32'h33334444}}, 1'b1);
    add_udp_patches(0);
    gap[1] = 5;
    gap[3] = 5;
    run_pkt(1'b0, 4, 200);
    idle(2);
    n_checks++;
    if (n_out !== 4) begin n_fail++; $display("FAIL gap_nbeats: got %0d, want 4", n_out); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== in_last[i]) begin
        n_fail++; $display("FAIL gap_beat%0d: got %h, want %h", i, out_data[i], exp_data[i]);
      end
    end
    n_checks++;
    if (bubble_viol !== 0) begin n_fail++; $display("FAIL gap_bubble: got %0d bubble beats, want 0", bubble_viol); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p0;
    p0 = pkt_cnt;
    clear_pkt();
    add_beat(mk_beat0(8'h06), 1'b0);
    add_beat(mk_beat1(), 1'b1);
    add_beat(mk_beat0(8'h11), 1'b1);
    run_pkt(1'b0, 3, 100);
    idle(2);
    n_checks++;
    if (n_out !== 3) begin n_fail++; $display("FAIL b2b_nbeats: got %0d, want 3", n_out); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_data[i] !== in_data[i] || out_last[i] !== in_last[i]) begin
        n_fail++; $display("FAIL b2b_beat%0d: got %h, want %h", i, out_data[i], in_data[i]);
      end
    end
    n_checks++;
    if (pkt_cnt - p0 !== 32'd2) begin n_fail++; $display("FAIL b2b_cnt: got +%0d, want +2", pkt_cnt - p0); end
  endtask

  task automatic test_reset_mid_body();
    clear_pkt();
    add_beat(mk_beat0(8'h11), 1'b0);
    add_beat(mk_beat1(), 1'b0);
    for (int i = 2; i < 6; i++) add_beat({8{32'hA5A50000 + 32'(i)}}, i == 5);
    run_pkt(1'b0, 3, 100);
    @(negedge clk);
    rst = 1'b1; empty = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || rd_en !== 1'b0 || m_tdata !== '0 ||
        m_tkeep !== '0 || m_tuser !== '0) begin
      n_fail++; $display("FAIL rstbody_out: got tvalid=%b tlast=%b rd_en=%b tdata=%h, want all 0", m_tvalid, m_tlast, rd_en, m_tdata);
    end
    n_checks++;
    if (pkt_cnt !== 32'd0 || mod_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rstbody_cnt: got pkt=%0d mod=%0d, want 0 0", pkt_cnt, mod_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_pkt();
    add_beat(mk_beat0(8'h11), 1'b0);
    add_beat(mk_beat1(), 1'b0);
    add_beat({8{32'h0BADF00D}}, 1'b1);
    add_udp_patches(0);
    run_pkt(1'b0, 3, 100);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== in_last[i]) begin
        n_fail++; $display("FAIL rstbody_beat%0d: got %h, want %h", i, out_data[i], exp_data[i]);
      end
    end
    n_checks++;
    if (pkt_cnt !== 32'd1 || mod_cnt !== 32'd1) begin
      n_fail++; $display("FAIL rstbody_cnt2: got pkt=%0d mod=%0d, want 1 1", pkt_cnt, mod_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_udp();
    test_non_udp();
    test_single_beat();
    test_random_ready();
    test_fifo_gaps();
    test_back_to_back();
    test_reset_mid_body();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
